// File: rtl/rv_fetch_prefetch_unit_if.sv
// Handshake bundle between the fetch front end, instruction memory and decode.
// master = fetch unit side, slave = memory/decode environment side.
interface rv_fetch_prefetch_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;
  logic [31:0]     fetch_instr;
  logic [XLEN-1:0] fetch_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output fetch_valid, fetch_pc, fetch_instr, fetch_pc_plus4,
    input  fetch_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  fetch_valid, fetch_pc, fetch_instr, fetch_pc_plus4,
    output fetch_ready
  );
endinterface

// File: rtl/rv_fetch_prefetch_unit.sv
// RV32I fetch front end: sequential fetch to a variable-latency memory, prefetch FIFO
// toward decode, and redirect with flush and discard of in-flight responses.
module rv_fetch_prefetch_unit #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  rv_fetch_prefetch_if.master  bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [OW-1:0] MAX_OUT  = OW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTSTANDING - 1);

  logic [XLEN-1:0] req_pc;
  logic [OW-1:0]   outstanding, outstanding_nxt, discard_cnt;
  logic [XLEN-1:0] tag_q [MAX_OUTSTANDING];
  logic [TW-1:0]   tag_wr, tag_rd;
  logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
  logic [31:0]     fifo_instr [FIFO_DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;

  logic            credit_ok, req_valid, req_fire, rsp_fire, push, pop, fetch_valid;
  logic [XLEN-1:0] redirect_target;

  // Credit term reserves a FIFO slot for every response that could still be kept.
  always_comb begin
    credit_ok       = (32'(outstanding) + 32'(count)) < 32'(FIFO_DEPTH);
    req_valid       = !reset && !redirect_valid && (outstanding < MAX_OUT) && credit_ok;
    req_fire        = req_valid && bus.imem_req_ready;
    rsp_fire        = bus.imem_rsp_valid && (outstanding != '0);
    push            = rsp_fire && !redirect_valid && (discard_cnt == '0);
    fetch_valid     = (count != '0) && !redirect_valid;
    pop             = fetch_valid && bus.fetch_ready;
    outstanding_nxt = outstanding + OW'(req_fire) - OW'(rsp_fire);
    redirect_target = redirect_pc & ~XLEN'(3);
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = req_pc;
  assign bus.fetch_valid    = fetch_valid;
  assign bus.fetch_pc       = fifo_pc[head];
  assign bus.fetch_instr    = fifo_instr[head];
  assign bus.fetch_pc_plus4 = fifo_pc[head] + XLEN'(4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_pc      <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) tag_q[i] <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else begin
      outstanding <= outstanding_nxt;
      if (req_fire) begin
        tag_q[tag_wr] <= req_pc;
        tag_wr        <= (tag_wr == TAG_LAST) ? '0 : tag_wr + TW'(1);
        req_pc        <= req_pc + XLEN'(4);
      end
      // Tags are consumed even for discarded responses so the queue stays in request order.
      if (rsp_fire)
        tag_rd <= (tag_rd == TAG_LAST) ? '0 : tag_rd + TW'(1);
      if (redirect_valid) begin
        req_pc      <= redirect_target;
        discard_cnt <= outstanding_nxt;
        head        <= '0;
        tail        <= '0;
        count       <= '0;
      end else begin
        if (rsp_fire && (discard_cnt != '0))
          discard_cnt <= discard_cnt - OW'(1);
        if (push) begin
          fifo_pc[tail]    <= tag_q[tag_rd];
          fifo_instr[tail] <= bus.imem_rsp_data;
          tail             <= tail + AW'(1);
        end
        if (pop)
          head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_rv_fetch_prefetch_unit.sv
// Bench for rv_fetch_prefetch_unit: directed scenarios then random traffic, checked
// against a queue-based model of the fetch stream.
module tb_rv_fetch_prefetch_unit;
  localparam int unsigned XLEN = 32;
  localparam int unsigned FD   = 4;
  localparam int unsigned MO   = 2;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  rv_fetch_prefetch_if #(.XLEN(XLEN)) bus ();

  rv_fetch_prefetch_unit #(
    .XLEN(XLEN), .RESET_PC(RST_PC), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
  typedef struct { logic [31:0] pc; bit drop; } flight_t;
  typedef struct { int unsigned due; logic [31:0] data; } mrsp_t;

  entry_t      ref_fifo[$];
  flight_t     ref_fl[$];
  logic [31:0] ref_pc;
  mrsp_t       mq[$];
  int unsigned cyc, mem_lat, last_due;
  bit          spurious;
  int unsigned n_cmp = 0, n_bad = 0;

  logic        nx_redir = 1'b0, nx_ready = 1'b1, nx_fready = 1'b1, nx_spur = 1'b0;
  logic [31:0] nx_rpc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00500093;
      32'h4:   return 32'h00A00113;
      32'h8:   return 32'h002081B3;
      32'hC:   return 32'h00000013;
      default: return (a * 32'h9E3779B1) ^ 32'h00000013;
    endcase
  endfunction

  function automatic bit ref_req_valid();
    return !redirect_valid && (ref_fl.size() < MO) && (ref_fl.size() + ref_fifo.size() < FD);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, ref_req_valid()});
    chk("req_addr", bus.imem_req_addr, ref_pc);
    chk("fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, (ref_fifo.size() > 0) && !redirect_valid});
    if (ref_fifo.size() > 0) begin
      chk("fetch_pc", bus.fetch_pc, ref_fifo[0].pc);
      chk("fetch_instr", bus.fetch_instr, ref_fifo[0].instr);
      chk("fetch_pc_plus4", bus.fetch_pc_plus4, ref_fifo[0].pc + 32'd4);
    end
  endtask

  task automatic apply();
    redirect_valid     = nx_redir;
    redirect_pc        = nx_rpc;
    bus.imem_req_ready = nx_ready;
    bus.fetch_ready    = nx_fready;
    spurious           = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mq[0].data;
    end else if (nx_spur && mq.size() == 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = $urandom;
      spurious           = 1'b1;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
  endtask

  // One clock: account for this cycle's handshakes, advance, drive, check.
  task automatic tick();
    bit rq, rs, pop;
    int unsigned due;
    flight_t f;
    rq  = ref_req_valid() && bus.imem_req_ready;
    rs  = bus.imem_rsp_valid && (ref_fl.size() > 0);
    pop = (ref_fifo.size() > 0) && !redirect_valid && bus.fetch_ready;
    if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready) begin
      due = cyc + mem_lat;
      if (due <= last_due) due = last_due + 1;
      mq.push_back('{due, mem_word(bus.imem_req_addr)});
      last_due = due;
    end
    if (bus.imem_rsp_valid && !spurious) void'(mq.pop_front());
    if (redirect_valid) begin
      if (rs) void'(ref_fl.pop_front());
      foreach (ref_fl[i]) ref_fl[i].drop = 1'b1;
      ref_fifo.delete();
      ref_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (pop) void'(ref_fifo.pop_front());
      if (rs) begin
        f = ref_fl.pop_front();
        if (!f.drop) ref_fifo.push_back('{f.pc, mem_word(f.pc)});
      end
      if (rq) begin
        ref_fl.push_back('{ref_pc, 1'b0});
        ref_pc = ref_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    apply();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    #3;
    reset              = 1'b1;
    redirect_valid     = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.fetch_ready    = 1'b0;
    spurious           = 1'b0;
    mq.delete();
    ref_fifo.delete();
    ref_fl.delete();
    ref_pc   = RST_PC;
    last_due = 0;
    #1;
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, RST_PC);
    chk("rst_fetch_valid", {31'b0, bus.fetch_valid}, 32'd0);
    chk("rst_fetch_pc", bus.fetch_pc, 32'd0);
    chk("rst_fetch_instr", bus.fetch_instr, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 1;
    apply();
    #1;
    check_outputs();
  endtask

  task automatic wait_fetch(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (bus.fetch_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    assert (n < budget) else begin
      n_bad++;
      $error("FAIL %s: fetch_valid not seen within %0d cycles, required within budget", tag, budget);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t1_exp [4];
    int unsigned first, idx;
    t1_exp = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013};

    // Full-rate stream at latency 1
    mem_lat = 1; nx_ready = 1; nx_fready = 1; nx_redir = 0; nx_spur = 0;
    do_reset();
    first = 0;
    for (int i = 0; i < 8 && first == 0; i++) begin
      if (bus.fetch_valid === 1'b1) first = cyc;
      else tick();
    end
    chk("first_valid_cycle", first, 32'd3);
    for (int unsigned i = 0; i < 4; i++) begin
      chk("t1_valid", {31'b0, bus.fetch_valid}, 32'd1);
      chk("t1_pc", bus.fetch_pc, i * 4);
      chk("t1_instr", bus.fetch_instr, t1_exp[i]);
      tick();
    end

    // Decode stall fills the FIFO, then drains in order
    nx_fready = 0;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    chk("t2_req_blocked", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("t2_head_pc", bus.fetch_pc, 32'd0);
    nx_fready = 1;
    idx = 0;
    for (int i = 0; i < 30 && idx < 5; i++) begin
      tick();
      if (bus.fetch_valid === 1'b1) begin
        chk("t2_drain_pc", bus.fetch_pc, idx * 4);
        idx++;
      end
    end
    chk("t2_drain_count", idx, 32'd5);

    // Redirect with two requests in flight at latency 3
    mem_lat = 3;
    do_reset();
    tick();
    nx_redir = 1; nx_rpc = 32'h103;
    tick();
    nx_redir = 0;
    for (int i = 0; i < 10 && bus.imem_req_valid !== 1'b1; i++) tick();
    chk("t3_req_addr", bus.imem_req_addr, 32'h100);
    wait_fetch("t3_wait", 20);
    chk("t3_fetch_pc", bus.fetch_pc, 32'h100);
    chk("t3_fetch_instr", bus.fetch_instr, mem_word(32'h100));

    // Redirect coinciding with a response while decode holds valid entries
    mem_lat = 2; nx_fready = 0;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    nx_redir = 1; nx_rpc = 32'h200; nx_fready = 1;
    tick();
    chk("t4_redir_fetch_valid", {31'b0, bus.fetch_valid}, 32'd0);
    nx_redir = 0;
    tick();
    chk("t4_flushed", {31'b0, bus.fetch_valid}, 32'd0);
    wait_fetch("t4_wait", 20);
    chk("t4_fetch_pc", bus.fetch_pc, 32'h200);

    // Memory stall holds the request; redirect withdraws it
    mem_lat = 1; nx_ready = 0; nx_fready = 1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", {31'b0, bus.imem_req_valid}, 32'd1);
      chk("t5_hold_addr", bus.imem_req_addr, 32'h0);
      tick();
    end
    nx_redir = 1; nx_rpc = 32'h40;
    tick();
    chk("t5_withdraw", {31'b0, bus.imem_req_valid}, 32'd0);
    nx_redir = 0; nx_ready = 1;
    tick();
    chk("t5_new_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("t5_new_addr", bus.imem_req_addr, 32'h40);
    for (int i = 0; i < 6; i++) tick();

    // PC wrap at the top of the address space, then async reset mid-burst
    do_reset();
    nx_redir = 1; nx_rpc = 32'hFFFF_FFFC;
    tick();
    nx_redir = 0;
    wait_fetch("t6_wait_top", 20);
    chk("t6_pc_top", bus.fetch_pc, 32'hFFFF_FFFC);
    chk("t6_plus4_wrap", bus.fetch_pc_plus4, 32'h0);
    tick();
    wait_fetch("t6_wait_wrap", 20);
    chk("t6_pc_wrap", bus.fetch_pc, 32'h0);
    tick();
    do_reset();

    // Random traffic: variable latency, stalls, redirects, stray responses
    for (int i = 0; i < 2000; i++) begin
      nx_ready  = ($urandom_range(0, 3) != 0);
      nx_fready = ($urandom_range(0, 3) != 0);
      mem_lat   = $urandom_range(1, 4);
      nx_redir  = ($urandom_range(0, 15) == 0);
      nx_rpc    = $urandom;
      nx_spur   = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
